// File: rtl/adder_pkg.sv
// Shared types and helpers for the pipelined prefix adder.
package adder_pkg;

   // Operation select: bit 0 chooses ~y, bit 1 chooses cin as the injected carry.
   typedef enum logic [1:0] {
      ADD  = 2'b00,
      SUB  = 2'b01,
      ADDC = 2'b10,
      SUBB = 2'b11
   } adder_op_t;

   // Ceiling log2, used to size the prefix tree depth.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/prefix_tree.sv
// Purely combinational Sklansky parallel-prefix carry tree.
// G[i] is the group generate over bits i..0 of the (g, p) inputs.
module prefix_tree
   import adder_pkg::*;
#(
   parameter int N = 7
) (
   input  logic [N-1:0] g,
   input  logic [N-1:0] p,
   output logic [N-1:0] G
);

   localparam int LEVELS = clog2(N);

   logic [N-1:0] gl [0:LEVELS];
   logic [N-1:0] pl [0:LEVELS];

   // At level l every bit whose index has bit l set merges with the top bit of the lower half-block.
   always_comb begin
      for (int l = 0; l <= LEVELS; l++) begin
         gl[l] = '0;
         pl[l] = '0;
      end
      gl[0] = g;
      pl[0] = p;
      for (int l = 0; l < LEVELS; l++) begin
         for (int i = 0; i < N; i++) begin
            if (((i >> l) & 1) == 1) begin
               gl[l+1][i] = gl[l][i] | (pl[l][i] & gl[l][((i >> l) << l) - 1]);
               pl[l+1][i] = pl[l][i] & pl[l][((i >> l) << l) - 1];
            end else begin
               gl[l+1][i] = gl[l][i];
               pl[l+1][i] = pl[l][i];
            end
         end
      end
   end

   assign G = gl[LEVELS];

endmodule

// File: rtl/prefix_adder_pipe.sv
// Three-stage pipelined Sklansky adder/subtractor with valid/ready flow control.
// S0 holds bitwise g/p/h and the injected carry, S1 holds the prefix carries,
// S2 holds the registered sum, carry-out and signed overflow.
module prefix_adder_pipe
   import adder_pkg::*;
#(
   parameter int WIDTH = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             cin,
   input  logic [1:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   s,
   output logic             ovf
);

   logic [WIDTH-1:0] b_in;
   logic             c0_in;

   logic             v0, v1, v2;
   logic             load0, load1, load2;

   logic [WIDTH-1:0] g0, p0, h0;
   logic             c0_r;
   logic [WIDTH-1:0] h1;
   logic [WIDTH:0]   carry1;
   logic [WIDTH:0]   carry_tree;

   // Decode the operation into the second operand and the carry injected below bit 0.
   always_comb begin
      b_in  = y;
      c0_in = 1'b0;
      case (adder_op_t'(op))
         ADD:  begin b_in = y;  c0_in = 1'b0; end
         SUB:  begin b_in = ~y; c0_in = 1'b1; end
         ADDC: begin b_in = y;  c0_in = cin;  end
         SUBB: begin b_in = ~y; c0_in = cin;  end
         default: begin b_in = y; c0_in = 1'b0; end
      endcase
   end

   // A stage loads when empty or when its successor moves on in the same cycle.
   assign load2     = !v2 || out_ready;
   assign load1     = !v1 || load2;
   assign load0     = !v0 || load1;
   assign in_ready  = load0;
   assign out_valid = v2;

   // The injected carry sits at position -1 as a pure generate with no propagate.
   prefix_tree #(
      .N(WIDTH + 1)
   ) u_tree (
      .g({g0, c0_r}),
      .p({p0, 1'b0}),
      .G(carry_tree)
   );

   // Valid bits advance on load and hold while stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         v0 <= 1'b0;
         v1 <= 1'b0;
         v2 <= 1'b0;
      end else begin
         if (load0) v0 <= in_valid;
         if (load1) v1 <= v0;
         if (load2) v2 <= v1;
      end
   end

   // S0 captures the bitwise generate/propagate/half-sum only on an accepted beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         g0   <= '0;
         p0   <= '0;
         h0   <= '0;
         c0_r <= 1'b0;
      end else if (in_valid && load0) begin
         g0   <= x & b_in;
         p0   <= x | b_in;
         h0   <= x ^ b_in;
         c0_r <= c0_in;
      end
   end

   // S1 captures the carry into every bit (carry1[i] = G[i-1:-1]) plus the half-sums.
   always_ff @(posedge clk) begin
      if (rst) begin
         h1     <= '0;
         carry1 <= '0;
      end else if (v0 && load1) begin
         h1     <= h0;
         carry1 <= carry_tree;
      end
   end

   // S2 forms the sum and overflow; it holds steady while the output is stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         s   <= '0;
         ovf <= 1'b0;
      end else if (v1 && load2) begin
         s   <= {carry1[WIDTH], h1 ^ carry1[WIDTH-1:0]};
         ovf <= carry1[WIDTH] ^ carry1[WIDTH-1];
      end
   end

endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Directed self-checking bench for prefix_adder_pipe at WIDTH 6, plus 2, 17 and 32.
module tb_prefix_adder_pipe;
   import adder_pkg::*;

   logic clk = 1'b0;
   logic rst;

   // Main 6-bit instance.
   logic       in_valid, in_ready, cin, out_valid, out_ready, ovf;
   logic [5:0] x, y;
   logic [1:0] op;
   logic [6:0] s;

   // Shared stimulus for the other widths.
   logic        w_valid, w_cin;
   logic [1:0]  w_op;
   logic [63:0] wx, wy;
   logic        rdy2, rdy17, rdy32, ov2, ov17, ov32, of2, of17, of32;
   logic [2:0]  s2;
   logic [17:0] s17;
   logic [32:0] s32;

   int checks = 0;
   int errors = 0;

   // Back-to-back vector table with hand-computed 6-bit results.
   logic [1:0] t_op  [8] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
   logic [5:0] t_x   [8] = '{6'd10, 6'd40, 6'd20, 6'd0, 6'd1, 6'd7, 6'd16, 6'd31};
   logic [5:0] t_y   [8] = '{6'd20, 6'd40, 6'd5, 6'd1, 6'd2, 6'd7, 6'd16, 6'd63};
   logic       t_cin [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
   logic [6:0] t_s   [8] = '{7'd30, 7'd80, 7'd79, 7'd63, 7'd4, 7'd64, 7'd32, 7'd32};
   logic       t_ovf [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

   always #5 clk = ~clk;

   prefix_adder_pipe #(.WIDTH(6)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .x(x), .y(y), .cin(cin), .op(op),
      .out_valid(out_valid), .out_ready(out_ready), .s(s), .ovf(ovf)
   );

   prefix_adder_pipe #(.WIDTH(2)) dut2 (
      .clk(clk), .rst(rst), .in_valid(w_valid), .in_ready(rdy2),
      .x(wx[1:0]), .y(wy[1:0]), .cin(w_cin), .op(w_op),
      .out_valid(ov2), .out_ready(1'b1), .s(s2), .ovf(of2)
   );

   prefix_adder_pipe #(.WIDTH(17)) dut17 (
      .clk(clk), .rst(rst), .in_valid(w_valid), .in_ready(rdy17),
      .x(wx[16:0]), .y(wy[16:0]), .cin(w_cin), .op(w_op),
      .out_valid(ov17), .out_ready(1'b1), .s(s17), .ovf(of17)
   );

   prefix_adder_pipe #(.WIDTH(32)) dut32 (
      .clk(clk), .rst(rst), .in_valid(w_valid), .in_ready(rdy32),
      .x(wx[31:0]), .y(wy[31:0]), .cin(w_cin), .op(w_op),
      .out_valid(ov32), .out_ready(1'b1), .s(s32), .ovf(of32)
   );

   // Reference for width w: {ovf, s} of x + (y or ~y) + c0, independent of any carry tree.
   function automatic logic [65:0] ref_model(input int w, input logic [63:0] xv, input logic [63:0] yv,
                                             input logic [1:0] opv, input logic cinv);
      logic [64:0] mask, xa, bb, full;
      logic        c0, ov;
      mask = (65'd1 << w) - 65'd1;
      xa   = {1'b0, xv} & mask;
      bb   = {1'b0, (opv[0] ? ~yv : yv)} & mask;
      c0   = opv[1] ? cinv : opv[0];
      full = xa + bb + {64'd0, c0};
      full = full & ((65'd1 << (w + 1)) - 65'd1);
      ov   = (xa[w-1] == bb[w-1]) && (full[w-1] != xa[w-1]);
      return {ov, full};
   endfunction

   // Drive one beat into the 6-bit instance and wait until its result should be on the output.
   task automatic applyStimulus(input logic [1:0] o, input logic [5:0] a, input logic [5:0] bv, input logic c);
      op = o; x = a; y = bv; cin = c; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; x = '0; y = '0; cin = 1'b0; op = 2'd0;
      w_valid = 1'b0; w_cin = 1'b0; w_op = 2'd0; wx = '0; wy = '0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", out_valid); end
      checks++; if (s !== 7'd0) begin errors++; $display("[TB] FAIL reset_s: got %0d expected 0", s); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf: got %b expected 0", ovf); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
      rst = 1'b0;
   endtask

   task automatic test_add();
      applyStimulus(2'd0, 6'd63, 6'd1, 1'b0);
      checks++; if (out_valid !== 1'b1 || s !== 7'd64 || ovf !== 1'b0) begin errors++;
         $display("[TB] FAIL add_63_1: got v=%b s=%0d ovf=%b expected v=1 s=64 ovf=0", out_valid, s, ovf); end
      applyStimulus(2'd0, 6'd31, 6'd1, 1'b0);
      checks++; if (out_valid !== 1'b1 || s !== 7'd32 || ovf !== 1'b1) begin errors++;
         $display("[TB] FAIL add_31_1: got v=%b s=%0d ovf=%b expected v=1 s=32 ovf=1", out_valid, s, ovf); end
   endtask

   task automatic test_sub();
      applyStimulus(2'd1, 6'd5, 6'd9, 1'b0);
      checks++; if (out_valid !== 1'b1 || s !== 7'd60 || ovf !== 1'b0) begin errors++;
         $display("[TB] FAIL sub_5_9: got v=%b s=%0d ovf=%b expected v=1 s=60 ovf=0", out_valid, s, ovf); end
      applyStimulus(2'd1, 6'd32, 6'd1, 1'b0);
      checks++; if (out_valid !== 1'b1 || s !== 7'd95 || ovf !== 1'b1) begin errors++;
         $display("[TB] FAIL sub_32_1: got v=%b s=%0d ovf=%b expected v=1 s=95 ovf=1", out_valid, s, ovf); end
   endtask

   task automatic test_carry_modes();
      applyStimulus(2'd2, 6'd0, 6'd63, 1'b1);
      checks++; if (s !== 7'd64 || ovf !== 1'b0) begin errors++;
         $display("[TB] FAIL addc_0_63_c1: got s=%0d ovf=%b expected s=64 ovf=0", s, ovf); end
      applyStimulus(2'd2, 6'd5, 6'd7, 1'b0);
      checks++; if (s !== 7'd12 || ovf !== 1'b0) begin errors++;
         $display("[TB] FAIL addc_5_7_c0: got s=%0d ovf=%b expected s=12 ovf=0", s, ovf); end
      applyStimulus(2'd3, 6'd10, 6'd3, 1'b0);
      checks++; if (s !== 7'd70 || ovf !== 1'b0) begin errors++;
         $display("[TB] FAIL subb_10_3_c0: got s=%0d ovf=%b expected s=70 ovf=0", s, ovf); end
      applyStimulus(2'd3, 6'd3, 6'd10, 1'b1);
      checks++; if (s !== 7'd57 || ovf !== 1'b0) begin errors++;
         $display("[TB] FAIL subb_3_10_c1: got s=%0d ovf=%b expected s=57 ovf=0", s, ovf); end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         if (c < 8) begin
            op = t_op[c]; x = t_x[c]; y = t_y[c]; cin = t_cin[c]; in_valid = 1'b1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_in_ready[%0d]: got %b expected 1", c, in_ready); end
         end else begin
            in_valid = 1'b0;
         end
         @(posedge clk); #1;
         if (c < 2) begin
            checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_latency[%0d]: got v=%b expected 0", c, out_valid); end
         end else begin
            checks++; if (out_valid !== 1'b1 || s !== t_s[c-2] || ovf !== t_ovf[c-2]) begin errors++;
               $display("[TB] FAIL b2b_result[%0d]: got v=%b s=%0d ovf=%b expected v=1 s=%0d ovf=%b", c-2, out_valid, s, ovf, t_s[c-2], t_ovf[c-2]); end
         end
      end
   endtask

   task automatic test_backpressure();
      int acc;
      int got;
      logic fire;
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      out_ready = 1'b0;
      acc = 0;
      for (int i = 0; i < 5; i++) begin
         op = t_op[acc]; x = t_x[acc]; y = t_y[acc]; cin = t_cin[acc]; in_valid = 1'b1;
         fire = in_ready;
         @(posedge clk); #1;
         if (fire) acc++;
         if (i >= 3) begin
            checks++; if (out_valid !== 1'b1 || s !== t_s[0]) begin errors++;
               $display("[TB] FAIL stall_hold[%0d]: got v=%b s=%0d expected v=1 s=%0d", i, out_valid, s, t_s[0]); end
         end
      end
      checks++; if (acc != 3) begin errors++; $display("[TB] FAIL stall_accepted: got %0d expected 3", acc); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL stall_in_ready: got %b expected 0", in_ready); end
      // Release while full and accept one more beat in the same cycle as the drain.
      out_ready = 1'b1;
      op = t_op[3]; x = t_x[3]; y = t_y[3]; cin = t_cin[3]; in_valid = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL full_accept_ready: got %b expected 1", in_ready); end
      got = 0;
      checks++; if (out_valid !== 1'b1 || s !== t_s[0]) begin errors++;
         $display("[TB] FAIL drain[0]: got v=%b s=%0d expected v=1 s=%0d", out_valid, s, t_s[0]); end
      got = 1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (out_valid === 1'b1) begin
            if (got < 8) begin
               checks++; if (s !== t_s[got]) begin errors++;
                  $display("[TB] FAIL drain[%0d]: got s=%0d expected s=%0d", got, s, t_s[got]); end
            end
            got++;
         end
         @(posedge clk); #1;
      end
      checks++; if (got != 4) begin errors++; $display("[TB] FAIL drain_count: got %0d expected 4", got); end
   endtask

   task automatic test_reset_in_flight();
      out_ready = 1'b1;
      op = t_op[1]; x = t_x[1]; y = t_y[1]; cin = t_cin[1]; in_valid = 1'b1;
      @(posedge clk); #1;
      op = t_op[6]; x = t_x[6]; y = t_y[6]; cin = t_cin[6];
      @(posedge clk); #1;
      in_valid = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++; if (out_valid !== 1'b0 || s !== 7'd0 || ovf !== 1'b0) begin errors++;
         $display("[TB] FAIL flight_reset: got v=%b s=%0d ovf=%b expected v=0 s=0 ovf=0", out_valid, s, ovf); end
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flight_stale[%0d]: got v=%b expected 0", i, out_valid); end
      end
   endtask

   task automatic test_widths();
      logic [63:0] vx [6];
      logic [63:0] vy [6];
      logic [1:0]  vop [6];
      logic        vc [6];
      logic [65:0] e;
      vx[0] = 64'hFFFF_FFFF_FFFF_FFFF; vy[0] = 64'd1;                  vop[0] = 2'd0; vc[0] = 1'b0;
      vx[1] = 64'd0;                  vy[1] = 64'd1;                  vop[1] = 2'd1; vc[1] = 1'b0;
      vx[2] = 64'h5555_5555_5555_5555; vy[2] = 64'hAAAA_AAAA_AAAA_AAAA; vop[2] = 2'd2; vc[2] = 1'b1;
      vx[3] = 64'h0001_0000_8000_0001; vy[3] = 64'd1;                  vop[3] = 2'd1; vc[3] = 1'b0;
      vx[4] = 64'h1234_5678_9ABC_DEF0; vy[4] = 64'h0FED_CBA9_8765_4321; vop[4] = 2'd3; vc[4] = 1'b1;
      vx[5] = {$urandom, $urandom};   vy[5] = {$urandom, $urandom};   vop[5] = 2'($urandom_range(0, 3)); vc[5] = 1'($urandom_range(0, 1));
      for (int v = 0; v < 6; v++) begin
         wx = vx[v]; wy = vy[v]; w_op = vop[v]; w_cin = vc[v]; w_valid = 1'b1;
         @(posedge clk); #1;
         w_valid = 1'b0;
         @(posedge clk);
         @(posedge clk); #1;
         e = ref_model(2, vx[v], vy[v], vop[v], vc[v]);
         checks++; if (ov2 !== 1'b1 || s2 !== e[2:0] || of2 !== e[65]) begin errors++;
            $display("[TB] FAIL w2[%0d]: got v=%b s=%h ovf=%b expected v=1 s=%h ovf=%b", v, ov2, s2, of2, e[2:0], e[65]); end
         e = ref_model(17, vx[v], vy[v], vop[v], vc[v]);
         checks++; if (ov17 !== 1'b1 || s17 !== e[17:0] || of17 !== e[65]) begin errors++;
            $display("[TB] FAIL w17[%0d]: got v=%b s=%h ovf=%b expected v=1 s=%h ovf=%b", v, ov17, s17, of17, e[17:0], e[65]); end
         e = ref_model(32, vx[v], vy[v], vop[v], vc[v]);
         checks++; if (ov32 !== 1'b1 || s32 !== e[32:0] || of32 !== e[65]) begin errors++;
            $display("[TB] FAIL w32[%0d]: got v=%b s=%h ovf=%b expected v=1 s=%h ovf=%b", v, ov32, s32, of32, e[32:0], e[65]); end
      end
   endtask

   // Top-level sequence of scenarios.
   initial begin
      test_reset();
      test_add();
      test_sub();
      test_carry_modes();
      test_back_to_back();
      test_backpressure();
      test_reset_in_flight();
      test_widths();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Guard against a hung run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/prefix_adder_pipe.md
# prefix_adder_pipe

Parametrised, pipelined parallel-prefix (Sklansky) adder/subtractor with valid/ready flow control. It generalises the fixed 6-bit combinational prefix adder to any operand width. It adds carry-in, subtract and borrow modes plus a signed-overflow flag, and registers the datapath in three stages so the adder can sit between streaming blocks at full clock rate.

## Interface
- WIDTH, 6, operand width in bits; legal range 2..64
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat this cycle
- x  in  WIDTH  operand A
- y  in  WIDTH  operand B
- cin  in  1  carry/borrow input; used by ADDC/SUBB only
- op  in  2  operation, encoded as adder_op_t
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- s  out  WIDTH+1  result; s[WIDTH] is the unsigned carry-out
- ovf  out  1  two's-complement signed overflow

## Operation
- Operations, with b = y or ~y and c0 the injected carry:
  - ADD (00): b = y, c0 = 0.
  - SUB (01): b = ~y, c0 = 1.
  - ADDC (10): b = y, c0 = cin.
  - SUBB (11): b = ~y, c0 = cin. Here cin = 1 means no borrow.
- s = x + b + c0, computed over WIDTH+1 bits.
  - For SUB/SUBB, s[WIDTH] = 1 means no borrow, i.e. x ≥ y unsigned.
- ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
- Pipeline stages:
  - S0: captures g_i = x_i & b_i, p_i = x_i | b_i, h_i = x_i ^ b_i and c0. c0 is merged as generate at position -1.
  - S1: captures prefix carries G[i:-1] for i = 0..WIDTH-1. Tree depth is ceil(log2(WIDTH+1)) levels, all combinational between S0 and S1.
  - S2: captures s_i = h_i ^ G[i-1:-1], plus s[WIDTH] = G[WIDTH-1:-1] and ovf.
- Flow control:
  - Each stage has a valid bit.
  - A stage loads when it is empty or its successor loads in the same cycle.
  - S2 drains when out_valid & out_ready.
  - in_ready = !v0 | stage S0 loads onward. This is combinational from out_ready through the stall chain; there is no skid buffer.
- Stalled stages hold both data and valid.
- Data registers load only on a transfer. Bubbles do not corrupt held results.

## Timing
- Reset (rst high at a clock edge):
  - All valid bits are cleared; out_valid = 0.
  - s = 0 and ovf = 0.
  - in_ready = 1 in the cycle after reset.
- Reset during operation discards all in-flight beats. No partial output appears after reset.
- Latency: a beat accepted at edge k has its result on s/ovf with out_valid = 1 after edge k+2.
- Throughput: 1 beat per cycle while out_ready = 1.
- Back-pressure:
  - With out_ready = 0 the pipeline fills. in_ready falls only when S0, S1 and S2 are all valid, so 3 beats can be buffered.
  - Deasserting and then reasserting out_ready loses no beat and duplicates no beat.
- Accept and drain can happen in the same cycle when full with out_ready = 1. in_ready stays 1 and the occupancy stays 3.
- s and ovf are stable while out_valid = 1 and out_ready = 0.
- Inputs x, y, cin and op are sampled only when in_valid & in_ready.

## Structure
- Package adder_pkg:
  - adder_op_t enum: ADD = 2'b00, SUB = 2'b01, ADDC = 2'b10, SUBB = 2'b11.
  - Function clog2 for tree depth.
- Sub-module prefix_tree #(N): purely combinational Sklansky tree.
  - Inputs: g[N-1:0], p[N-1:0].
  - Output: G[N-1:0], the group generate from bit 0 upward.
  - The top level instantiates it with N = WIDTH+1, with c0 prepended as bit 0.
- Top level holds only the stage registers, the valid/stall logic and the sum XOR.

## Test plan
- WIDTH=6, ADD, x=63, y=1, out_ready=1 -> after 2 edges s=7'b1000000 (64), ovf=0. Second case: x=31, y=1 -> s=32, ovf=1.
- SUB x=5, y=9 -> s[5:0]=60 (-4), s[6]=0 (borrow), ovf=0. SUB x=32, y=1 -> s[5:0]=31, s[6]=1, ovf=1.
- ADDC x=0, y=63, cin=1 -> s=64. SUBB x=10, y=3, cin=0 -> s[5:0]=6, s[6]=1.
- Stream 8 random beats back-to-back with out_ready=1 -> 8 results in order, one per cycle, in_ready stays 1.
- Stream with out_ready held low 5 cycles -> in_ready drops after 3 accepted beats. On release all beats emerge in order, no loss or duplicate.
- Pulse rst with 2 beats in flight -> out_valid=0, s=0 next cycle, no stale beat ever emitted. Repeat the suite with WIDTH=2, 17 and 32 against a reference model of x+b+c0.
